// File: rtl/medidor_pkg.sv
// medidor_pkg: shared state type, default sizes and
// gate counter width helper for the frequency meter.
package medidor_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      GATE = 1'b1
   } estado_t;

   localparam int GATE_CYCLES_DEF = 100_000_000;
   localparam int COUNT_W_DEF     = 27;

   function automatic int ancho_compuerta(input int ciclos);
      return (ciclos < 2) ? 1 : $clog2(ciclos);
   endfunction

endpackage

// File: rtl/medidor_frecuencia_sincronizador.sv
// sincronizador_flanco: two-flop synchronizer plus history
// flop; emits a one-cycle pulse on each synchronized rise.
module sincronizador_flanco (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_sig,
   output logic o_rise
);

   logic r_s1;
   logic r_s2;
   logic r_s3;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= i_sig;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/medidor_frecuencia.sv
// medidor_frecuencia: counts SIG_IN rising edges over a
// fixed gate window and publishes the count with VALID.
module medidor_frecuencia
   import medidor_pkg::*;
#(
   parameter int GATE_CYCLES = GATE_CYCLES_DEF,
   parameter int COUNT_W     = COUNT_W_DEF
) (
   input  logic               CLK_100MHZ,
   input  logic               RST_N,
   input  logic               EN,
   input  logic               SIG_IN,
   output logic [COUNT_W-1:0] FREQ,
   output logic               VALID,
   output logic               OVF,
   output logic               BUSY
);

   localparam int GW = ancho_compuerta(GATE_CYCLES);
   localparam logic [GW-1:0] GATE_LAST =
      GW'(GATE_CYCLES - 1);
   localparam logic [COUNT_W-1:0] CNT_MAX =
      {COUNT_W{1'b1}};

   estado_t            r_estado;
   estado_t            w_estado_sig;
   logic [GW-1:0]      r_gate;
   logic [COUNT_W-1:0] r_edge;
   logic               r_sat;
   logic [COUNT_W-1:0] r_freq;
   logic               r_valid;
   logic               r_ovf;

   logic               w_rise;
   logic               w_fin;
   logic               w_publica;
   logic               w_limpia;
   logic [COUNT_W:0]   w_suma;
   logic               w_desborde;
   logic [COUNT_W-1:0] w_edge_sat;

   sincronizador_flanco u_sinc (
      .i_clk   (CLK_100MHZ),
      .i_rst_n (RST_N),
      .i_sig   (SIG_IN),
      .o_rise  (w_rise)
   );

   assign w_fin = (r_gate == GATE_LAST);

   // one extra bit catches the wrap so the count saturates
   assign w_suma = {1'b0, r_edge}
                 + {{COUNT_W{1'b0}}, w_rise};
   assign w_desborde = w_suma[COUNT_W];
   assign w_edge_sat = w_desborde ? CNT_MAX
                                  : w_suma[COUNT_W-1:0];

   always_ff @(posedge CLK_100MHZ or negedge RST_N) begin
      if (!RST_N) begin
         r_estado <= IDLE;
      end else begin
         r_estado <= w_estado_sig;
      end
   end

   always_comb begin
      w_estado_sig = r_estado;
      w_publica    = 1'b0;
      unique case (r_estado)
         IDLE: begin
            if (EN) begin
               w_estado_sig = GATE;
            end
         end
         GATE: begin
            w_publica = w_fin;
            if (!EN) begin
               w_estado_sig = IDLE;
            end
         end
      endcase
   end

   // publish and abort both restart the window from zero
   assign w_limpia = (r_estado == IDLE)
                   | (w_estado_sig == IDLE)
                   | w_publica;

   always_ff @(posedge CLK_100MHZ or negedge RST_N) begin
      if (!RST_N) begin
         r_gate <= '0;
         r_edge <= '0;
         r_sat  <= 1'b0;
      end else if (w_limpia) begin
         r_gate <= '0;
         r_edge <= '0;
         r_sat  <= 1'b0;
      end else begin
         r_gate <= r_gate + GW'(1);
         r_edge <= w_edge_sat;
         r_sat  <= r_sat | w_desborde;
      end
   end

   always_ff @(posedge CLK_100MHZ or negedge RST_N) begin
      if (!RST_N) begin
         r_freq  <= '0;
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_valid <= w_publica;
         if (w_publica) begin
            r_freq <= w_edge_sat;
            r_ovf  <= r_sat | w_desborde;
         end
      end
   end

   assign FREQ  = r_freq;
   assign VALID = r_valid;
   assign OVF   = r_ovf;
   assign BUSY  = (r_estado == GATE);

endmodule

// File: tb/tb_medidor_frecuencia.sv
// tb_medidor_frecuencia: randomized bench with a window-level
// reference model of the frequency meter.
module tb_medidor_frecuencia;

   localparam int G    = 1000;
   localparam int W    = 8;
   localparam int MAXF = (1 << W) - 1;
   localparam int MAXC = 65536;

   logic         CLK_100MHZ = 1'b0;
   logic         RST_N      = 1'b0;
   logic         EN         = 1'b0;
   logic         SIG_IN     = 1'b0;
   logic [W-1:0] FREQ;
   logic         VALID;
   logic         OVF;
   logic         BUSY;

   int n_chk = 0;
   int n_err = 0;

   medidor_frecuencia #(
      .GATE_CYCLES (G),
      .COUNT_W     (W)
   ) dut (
      .CLK_100MHZ (CLK_100MHZ),
      .RST_N      (RST_N),
      .EN         (EN),
      .SIG_IN     (SIG_IN),
      .FREQ       (FREQ),
      .VALID      (VALID),
      .OVF        (OVF),
      .BUSY       (BUSY)
   );

   always #5 CLK_100MHZ = ~CLK_100MHZ;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d",
                  tag, got, exp);
      end
   endtask

   // signal generator: 0 stuck, 1 fixed half period,
   // 2 random toggles, 3 random half periods
   int g_mode = 0;
   int g_lvl  = 0;
   int g_half = 5;
   int g_ph   = 0;
   int g_rh   = 1;
   int gen_rises = 0;
   logic g_prev = 1'b0;

   always @(negedge CLK_100MHZ) begin
      case (g_mode)
         0: SIG_IN = g_lvl[0];
         1: begin
            g_ph++;
            if (g_ph >= g_half) begin
               g_ph = 0;
               SIG_IN = ~SIG_IN;
            end
         end
         2: begin
            if ($urandom_range(7) == 0) SIG_IN = ~SIG_IN;
         end
         default: begin
            g_ph++;
            if (g_ph >= g_rh) begin
               g_ph = 0;
               SIG_IN = ~SIG_IN;
               g_rh = $urandom_range(6, 1);
            end
         end
      endcase
      if (SIG_IN && !g_prev) gen_rises++;
      g_prev = SIG_IN;
   end

   // reference: a rise sampled at edge k lands in the window
   // whose publish edge P satisfies P-G-1 <= k <= P-2
   bit   srise [MAXC];
   int   cyc     = 0;
   int   m_start = 0;
   int   m_n     = 0;
   int   m_freq  = 0;
   bit   m_busy  = 0;
   bit   m_valid = 0;
   bit   m_ovf   = 0;
   logic m_prev  = 1'b0;

   always @(posedge CLK_100MHZ) begin
      cyc++;
      if (!RST_N) begin
         srise[cyc % MAXC] = 1'b0;
         m_prev  = 1'b0;
         m_busy  = 1'b0;
         m_valid = 1'b0;
         m_freq  = 0;
         m_ovf   = 1'b0;
      end else begin
         srise[cyc % MAXC] = SIG_IN & ~m_prev;
         m_prev  = SIG_IN;
         m_valid = 1'b0;
         if (!m_busy) begin
            if (EN) begin
               m_busy  = 1'b1;
               m_start = cyc;
            end
         end else if (cyc - m_start == G) begin
            m_n = 0;
            for (int j = cyc - G - 1; j <= cyc - 2; j++)
               m_n += int'(srise[j % MAXC]);
            m_freq  = (m_n > MAXF) ? MAXF : m_n;
            m_ovf   = (m_n > MAXF);
            m_valid = 1'b1;
            if (EN) m_start = cyc;
            else m_busy = 1'b0;
         end else if (!EN) begin
            m_busy = 1'b0;
         end
      end
   end

   int sum_freq = 0;
   int n_win    = 0;

   task automatic wait_valid(input int budget,
                             output int n);
      n = 0;
      do begin
         @(negedge CLK_100MHZ);
         n++;
      end while (!VALID && n < budget);
      check("valid_seen", VALID, 1);
   endtask

   int n, v, g0, s0, w0, d;

   initial begin
      fork
         forever begin
            @(negedge CLK_100MHZ);
            check("valid", VALID, RST_N ? m_valid : 0);
            check("busy", BUSY, RST_N ? m_busy : 0);
            check("freq", FREQ, RST_N ? m_freq : 0);
            check("ovf", OVF, RST_N ? m_ovf : 0);
            if (VALID) begin
               sum_freq += int'(FREQ);
               n_win++;
            end
         end
      join_none

      repeat (3) @(negedge CLK_100MHZ);
      check("reset_outs", {FREQ, VALID, OVF, BUSY}, 0);
      #2 RST_N = 1'b1;
      repeat (3) @(negedge CLK_100MHZ);

      // period 10, continuous enable
      g_half = 5;
      g_ph   = $urandom_range(4);
      g_mode = 1;
      EN     = 1'b1;
      wait_valid(1100, n);
      check("first_latency", n, G + 1);
      check("p10_first", (FREQ >= 99 && FREQ <= 101), 1);
      repeat (2) begin
         wait_valid(1100, n);
         check("p10_period", n, G);
         check("p10_freq", FREQ, 100);
         check("p10_ovf", OVF, 0);
      end

      // stuck low, then stuck high
      g_lvl  = 0;
      g_mode = 0;
      repeat (2) wait_valid(1100, n);
      check("stuck_lo", FREQ, 0);
      g_lvl = 1;
      repeat (2) wait_valid(1100, n);
      check("stuck_hi", FREQ, 0);

      // saturation at period 2, then recovery at period 20
      g_half = 1;
      g_mode = 1;
      repeat (2) wait_valid(1100, n);
      check("sat_freq", FREQ, MAXF);
      check("sat_ovf", OVF, 1);
      g_half = 10;
      repeat (2) wait_valid(1100, n);
      check("p20_freq", FREQ, 50);
      check("p20_ovf", OVF, 0);

      // abort at cycle 600 of a window
      repeat (599) @(negedge CLK_100MHZ);
      EN = 1'b0;
      @(negedge CLK_100MHZ);
      check("abort_busy", BUSY, 0);
      v = 0;
      repeat (500) begin
         @(negedge CLK_100MHZ);
         if (VALID) v++;
      end
      check("abort_novalid", v, 0);
      check("abort_hold", FREQ, 50);
      EN = 1'b1;
      wait_valid(1100, n);
      check("reraise_latency", n, G + 1);
      check("reraise_freq", FREQ, 50);

      // enable drops exactly in the publish cycle
      repeat (G - 1) @(negedge CLK_100MHZ);
      EN = 1'b0;
      wait_valid(5, n);
      check("pubdrop_valid", n, 1);
      check("pubdrop_freq", FREQ, 50);
      @(negedge CLK_100MHZ);
      check("pubdrop_idle", BUSY, 0);

      // asynchronous reset in the middle of a window
      g_mode = 2;
      EN = 1'b1;
      repeat (400) @(negedge CLK_100MHZ);
      @(posedge CLK_100MHZ);
      #2 RST_N = 1'b0;
      #1 check("rst_async", {FREQ, VALID, OVF, BUSY}, 0);
      repeat (3) @(negedge CLK_100MHZ);
      #2 RST_N = 1'b1;
      wait_valid(1100, n);
      check("rst_latency", n, G + 1);

      // ten contiguous windows lose no edges
      EN     = 1'b0;
      g_lvl  = 0;
      g_mode = 0;
      repeat (10) @(negedge CLK_100MHZ);
      g0 = gen_rises;
      s0 = sum_freq;
      w0 = n_win;
      g_mode = 2;
      EN = 1'b1;
      repeat (10 * G - 5) @(negedge CLK_100MHZ);
      g_mode = 0;
      repeat (20) @(negedge CLK_100MHZ);
      check("win_count", n_win - w0, 10);
      d = (sum_freq - s0) - (gen_rises - g0);
      check("edge_sum", (d >= -1 && d <= 1), 1);

      // random half periods with random enable spans
      g_mode = 3;
      repeat (8) begin
         EN = ~EN;
         repeat ($urandom_range(2500, 300))
            @(negedge CLK_100MHZ);
      end

      $display("Result: errors=%0d of %0d checks",
               n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/medidor_frecuencia.md
# medidor_frecuencia

Gated frequency meter, the measuring counterpart to our clock dividers. It counts rising edges of an external square wave (SIG_IN) over a fixed gate window timed from CLK_100MHZ and publishes the count with a one-cycle valid strobe. With the default gate of 10^8 cycles (1 s at 100 MHz), the published count equals the input frequency in Hz. It sits between an input pin or divider output and the display/readout logic.

## Interface
- GATE_CYCLES, 100_000_000: gate window length in CLK_100MHZ cycles; must be ≥ 4.
- COUNT_W, 27: width of the edge counter and FREQ.
- CLK_100MHZ  input  1  system clock; all logic on its rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- EN  input  1  measurement enable, synchronous to CLK_100MHZ.
- SIG_IN  input  1  signal to measure, asynchronous to CLK_100MHZ.
- FREQ  output  COUNT_W  edge count of the last completed window.
- VALID  output  1  one-cycle pulse when FREQ updates.
- OVF  output  1  the last completed window saturated the edge counter.
- BUSY  output  1  a gate window is in progress.

## Operation
- SIG_IN passes through a 2-flop synchronizer (s1, s2) and then a history flop s3.
- A rising edge is `rise = s2 & ~s3`. At most one edge is counted per cycle.
- FSM states:
  - IDLE: gate counter and edge counter held at 0; BUSY=0.
  - GATE: gate counter increments each cycle; edge counter increments on `rise`; BUSY=1.
- Transitions:
  - IDLE→GATE on the first cycle EN=1.
  - GATE→IDLE when EN=0: the window is aborted, with no VALID and FREQ/OVF unchanged.
  - GATE stays in GATE at the terminal cycle (gate counter = GATE_CYCLES-1), which is the publish cycle.
- Publish cycle:
  - FREQ ← edge_count + rise, saturated at 2^COUNT_W-1.
  - OVF ← 1 if saturation occurred in this window, else 0.
  - VALID ← 1.
  - Gate counter ← 0 and edge counter ← 0, so the next window starts back-to-back with no dead cycles.
- Edge counter saturates at 2^COUNT_W-1 and never wraps; a sticky saturation flag is cleared at window start.
- Gate counter width is clog2(GATE_CYCLES); it wraps only through the publish path.
- Measurable range: SIG_IN high and low phases must each be ≥ 1 clock period, so the maximum input frequency is < 50 MHz. Faster inputs undercount; this is accepted and not flagged.
- Reset (RST_N=0, any time, including mid-window):
  - State IDLE; synchronizer flops, counters, FREQ, VALID, OVF and BUSY all 0.
  - s3 resets to 0. A SIG_IN that is high at reset release therefore counts one edge 2 cycles after release; this is accepted.

## Timing
- Synchronizer latency: an edge on SIG_IN is reflected in `rise` 2–3 cycles later, depending on the sampling phase.
- Edges in the last ~2 cycles of a window are counted in the next window. No edge is lost or double-counted across contiguous windows.
- The first window starts on the cycle after EN is first sampled high, so BUSY rises 1 cycle after EN.
- VALID asserts exactly GATE_CYCLES cycles after BUSY rises, then every GATE_CYCLES cycles while EN stays 1.
- FREQ and OVF are registered, change only in the VALID cycle, and hold otherwise.
- EN falling in the publish cycle: the publish completes (VALID=1), then the FSM goes to IDLE.
- EN high again after an abort: a fresh window starts with counters at 0.

## Structure
- Shared package `medidor_pkg`:
  - State enum (IDLE, GATE).
  - Default GATE_CYCLES / COUNT_W constants.
  - The clog2-based gate counter width function.
- One sub-module, `sincronizador_flanco`: 2-flop synchronizer plus history flop and rising-edge pulse, with async active-low reset. The same block is reusable for buttons elsewhere.
- Top level holds the FSM, gate counter, saturating edge counter and output registers.

## Test plan
Bench parameters: GATE_CYCLES=1000, COUNT_W=8 unless stated.
- SIG_IN period 10 cycles (5 high/5 low), EN=1 continuous → VALID every 1000 cycles; FREQ=100 ±1 on the first window, exactly 100 on later windows; OVF=0.
- SIG_IN stuck low, then stuck high → FREQ=0 each window (a single transition adds at most 1 in that window).
- SIG_IN period 2 cycles with COUNT_W=8 → 500 edges saturate: FREQ=255, OVF=1. Then slow to period 20 → next full window FREQ=50, OVF=0.
- EN dropped at cycle 600 of a window → no VALID, BUSY=0 next cycle, FREQ keeps the previous value. EN re-raised → VALID 1000 cycles after BUSY rises.
- RST_N pulsed low asynchronously mid-window (between clock edges) → all outputs 0 immediately. After release with EN=1, the first VALID comes 1001 cycles later.
- Sum of FREQ over 10 contiguous windows equals the total generated edge count (±1 only for an edge still in flight in the synchronizer at the end) → no edge lost at window boundaries.
